// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants, divisor lookup and state type for the SPART driver
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Divisors for a 50 MHz system clock
  localparam logic [15:0] DIV_4800  = 16'h028A;
  localparam logic [15:0] DIV_9600  = 16'h0144;
  localparam logic [15:0] DIV_19200 = 16'h00A2;
  localparam logic [15:0] DIV_38400 = 16'h0050;

  typedef enum logic [2:0] {
    ST_CFG_LO,
    ST_CFG_HI,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_GAP
  } drv_state_e;

  function automatic logic [15:0] baud_divisor(input logic [1:0] sel);
    logic [15:0] div;
    case (sel)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/echo_fifo.sv
// rtl/echo_fifo.sv - 4x8 echo FIFO with 2-bit wrapping pointers and 3-bit occupancy
module echo_fifo
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [2:0] count_o
);

  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 3'd4);
  assign empty_o = (count_q == 3'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - SPART bus master: programs the baud divisor, then echoes received bytes
module spart_driver
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  input  logic       rda,
  input  logic       tbr,
  inout  wire  [7:0] databus,
  output logic [2:0] fifo_count
);

  drv_state_e state_q, state_d;
  logic [1:0] cfg_q, cfg_d;
  logic [1:0] sel_q, sel_d;
  logic       iocs_q, iocs_d;
  logic       iorw_q, iorw_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic       push, pop, fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic [15:0] div_w;

  echo_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (databus),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // High byte reuses the selection captured for the low byte
  assign div_w = baud_divisor((state_q == ST_CFG_LO) ? br_cfg : sel_q);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    sel_d   = sel_q;
    iocs_d  = 1'b0;
    iorw_d  = 1'b1;
    addr_d  = ADDR_BUF;
    dout_d  = dout_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_CFG_LO: begin
        iocs_d  = 1'b1;
        iorw_d  = 1'b0;
        addr_d  = ADDR_DBL;
        dout_d  = div_w[7:0];
        sel_d   = br_cfg;
        state_d = ST_CFG_HI;
      end
      ST_CFG_HI: begin
        iocs_d  = 1'b1;
        iorw_d  = 1'b0;
        addr_d  = ADDR_DBH;
        dout_d  = div_w[15:8];
        cfg_d   = sel_q;
        state_d = ST_GAP;
      end
      ST_IDLE: begin
        if (br_cfg != cfg_q) begin
          state_d = ST_CFG_LO;
        end else if (!fifo_empty && tbr) begin
          iocs_d  = 1'b1;
          iorw_d  = 1'b0;
          dout_d  = fifo_head;
          pop     = 1'b1;
          state_d = ST_WRITE;
        end else if (rda && !fifo_full) begin
          iocs_d  = 1'b1;
          state_d = ST_READ;
        end
      end
      // SPART drives the bus during this cycle; capture at its closing edge
      ST_READ: begin
        push    = 1'b1;
        state_d = ST_GAP;
      end
      ST_WRITE: state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_CFG_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CFG_LO;
      cfg_q   <= 2'b00;
      sel_q   <= 2'b00;
      iocs_q  <= 1'b0;
      iorw_q  <= 1'b1;
      addr_q  <= ADDR_BUF;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      sel_q   <= sel_d;
      iocs_q  <= iocs_d;
      iorw_q  <= iorw_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  assign iocs    = iocs_q;
  assign iorw    = iorw_q;
  assign ioaddr  = addr_q;
  assign databus = (iocs_q && !iorw_q) ? dout_q : 8'hzz;

endmodule
